cdb_arbiter: RTL

- Arbitrates the single common data bus (CDB) writeback slot among the functional-unit result producers: ALU, branch, MUL and LSU load-return.
- The winning result is registered and broadcast to the PRF write port, ROB completion and issue-queue wakeup.
- Mixes fixed priority for latency-critical units with round-robin for the rest.
- An anti-starvation counter guarantees that low-priority units make forward progress.

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr_pick.sv | 25 ++
 rtl/cdb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types and default widths used by the ROB, rename, PRF and the CDB arbiter.
package cdb_pkg;
    localparam int CDB_NUM_REQ   = 4;
    localparam int CDB_ROB_TAG_W = 5;
    localparam int CDB_PREG_W    = 7;
    localparam int CDB_DATA_W    = 32;

    typedef struct packed {
        logic [CDB_ROB_TAG_W-1:0] rob_tag;
        logic [CDB_PREG_W-1:0]    pd;
        logic                     we;
        logic [CDB_DATA_W-1:0]    data;
    } cdb_packet_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_STARVE,
        GNT_HIGH,
        GNT_RR
    } gnt_class_e;
endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Circular round-robin picker: first set request at or after ptr, wrapping to index 0.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                     req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic [N-1:0]                     gnt,
    output logic                             any
);
    logic [N-1:0] masked;

    // Search the upper window first; fall back to the full vector for the wrap.
    always_comb begin
        masked = '0;
        for (int j = 0; j < N; j++) begin
            masked[j] = req[j] && (j >= int'(ptr));
        end
        if (|masked) begin
            gnt = masked & (~masked + N'(1));
        end else begin
            gnt = req & (~req + N'(1));
        end
        any = |req;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: starved low-priority > high-priority > round-robin; winner registered onto the bus.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int                  NUM_REQ      = CDB_NUM_REQ,
    parameter int                  ROB_TAG_W    = CDB_ROB_TAG_W,
    parameter int                  PREG_W       = CDB_PREG_W,
    parameter int                  DATA_W       = CDB_DATA_W,
    parameter logic [NUM_REQ-1:0]  HI_PRI_MASK  = 4'b1000,
    parameter int                  STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ROB_TAG_W-1:0]   req_rob_tag,
    input  logic [NUM_REQ*PREG_W-1:0]      req_pd,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    output logic                           cdb_valid,
    output logic [ROB_TAG_W-1:0]           cdb_rob_tag,
    output logic [PREG_W-1:0]              cdb_pd,
    output logic                           cdb_we,
    output logic [DATA_W-1:0]              cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]     cdb_src
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0] lo_valid, hi_valid, starved, rr_gnt, grant;
    logic               rr_any;
    gnt_class_e         gclass;

    logic [SRC_W-1:0]   ptr_q, ptr_d, src_q, src_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    cdb_packet_t        pkt_q, pkt_d;
    logic               cdb_valid_q, cdb_valid_d;

    assign lo_valid = req_valid & ~HI_PRI_MASK;
    assign hi_valid = req_valid & HI_PRI_MASK;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = lo_valid[i] && (cnt_q[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req (lo_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    // v & -v isolates the lowest set bit, i.e. lowest-index winner.
    always_comb begin
        grant  = '0;
        gclass = GNT_NONE;
        if (reset && !flush) begin
            if (|starved) begin
                gclass = GNT_STARVE;
                grant  = starved & (~starved + NUM_REQ'(1));
            end else if (|hi_valid) begin
                gclass = GNT_HIGH;
                grant  = hi_valid & (~hi_valid + NUM_REQ'(1));
            end else if (rr_any) begin
                gclass = GNT_RR;
                grant  = rr_gnt;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        pkt_d       = pkt_q;
        src_d       = src_q;
        cdb_valid_d = |grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                src_d         = SRC_W'(i);
                pkt_d.rob_tag = req_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
                pkt_d.pd      = req_pd[i*PREG_W +: PREG_W];
                pkt_d.we      = req_we[i];
                pkt_d.data    = req_data[i*DATA_W +: DATA_W];
            end
        end

        ptr_d = ptr_q;
        if (gclass == GNT_RR) begin
            ptr_d = (src_d == SRC_W'(NUM_REQ - 1)) ? '0 : src_d + SRC_W'(1);
        end

        // High-priority units never accumulate wait credit.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush || HI_PRI_MASK[i] || !req_valid[i] || grant[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CNT_W'(STARVE_LIMIT)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cdb_valid_q <= 1'b0;
            pkt_q       <= '0;
            src_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '{default: '0};
        end else begin
            cdb_valid_q <= cdb_valid_d;
            pkt_q       <= pkt_d;
            src_q       <= src_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_tag = pkt_q.rob_tag;
    assign cdb_pd      = pkt_q.pd;
    assign cdb_we      = pkt_q.we;
    assign cdb_data    = pkt_q.data;
    assign cdb_src     = src_q;
endmodule
